// File: rtl/writeback_stage.sv
// writeback_stage
// Final pipeline stage. Holds the MEM/WB register, buffers the synchronous
// data SRAM read data so a stall cannot lose it, aligns/extends load data
// (including the LWL/LWR merge), and drives the register-file write port,
// the decode bypass and the debug trace.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   ms_*                   instruction presented by memory_stage
//   data_sram_rdata        SRAM read data, valid in the first WB cycle only
//   ws_hold                external stall, WB keeps its instruction
//   ws_allowin             WB accepts a new instruction at the next edge
//   rf_we/rf_waddr/rf_wdata register-file write port
//   ws_fwd_dest/ws_fwd_data bypass to decode (dest 0 = no bypass)
//   debug_wb_*             trace interface
module writeback_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ms_valid,
    input  logic [31:0] ms_pc,
    input  logic [31:0] ms_alu_result,
    input  logic [31:0] ms_rt_value,
    input  logic [4:0]  ms_dest,
    input  logic        ms_gr_we,
    input  logic [2:0]  ms_load_op,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_hold,
    output logic        ws_allowin,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [4:0]  ws_fwd_dest,
    output logic [31:0] ws_fwd_data,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    logic        ws_valid;
    logic        ws_first;
    logic        ws_ready_go;
    logic        ms_accept;
    logic [31:0] ws_pc;
    logic [31:0] ws_alu_result;
    logic [31:0] ws_rt_value;
    logic [4:0]  ws_dest;
    logic        ws_gr_we;
    logic [2:0]  ws_load_op;
    logic [31:0] rdata_buf;
    logic [31:0] rd;
    logic [31:0] ws_result;

    // Byte/halfword selection, extension and the unaligned-word merge.
    function automatic logic [31:0] load_align(
        input logic [2:0]  op,
        input logic [1:0]  k,
        input logic [31:0] alu,
        input logic [31:0] rt,
        input logic [31:0] rdat
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdat[{k, 3'b000} +: 8];
        h = k[1] ? rdat[31:16] : rdat[15:0];
        r = alu;
        case (op)
            3'd0: r = alu;
            3'd1: r = {{24{b[7]}}, b};
            3'd2: r = {24'd0, b};
            3'd3: r = {{16{h[15]}}, h};
            3'd4: r = {16'd0, h};
            3'd5: r = rdat;
            3'd6: begin
                // LWL: low bytes of memory word fill the high end of rt
                case (k)
                    2'd0:    r = {rdat[7:0],  rt[23:0]};
                    2'd1:    r = {rdat[15:0], rt[15:0]};
                    2'd2:    r = {rdat[23:0], rt[7:0]};
                    default: r = rdat;
                endcase
            end
            default: begin
                // LWR: high bytes of memory word fill the low end of rt
                case (k)
                    2'd0:    r = rdat;
                    2'd1:    r = {rt[31:24], rdat[31:8]};
                    2'd2:    r = {rt[31:16], rdat[31:16]};
                    default: r = {rt[31:8],  rdat[31:24]};
                endcase
            end
        endcase
        return r;
    endfunction

    assign ws_ready_go = !ws_hold;
    assign ws_allowin  = !ws_valid || ws_ready_go;
    assign ms_accept   = ms_valid && ws_allowin;

    // MEM -> WB boundary: control
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
            ws_first <= 1'b0;
        end else begin
            if (ws_allowin) begin
                ws_valid <= ms_valid;
            end
            ws_first <= ms_accept;
        end
    end

    // MEM -> WB boundary: payload
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_pc         <= 32'd0;
            ws_alu_result <= 32'd0;
            ws_rt_value   <= 32'd0;
            ws_dest       <= 5'd0;
            ws_gr_we      <= 1'b0;
            ws_load_op    <= 3'd0;
        end else if (ms_accept) begin
            ws_pc         <= ms_pc;
            ws_alu_result <= ms_alu_result;
            ws_rt_value   <= ms_rt_value;
            ws_dest       <= ms_dest;
            ws_gr_we      <= ms_gr_we;
            ws_load_op    <= ms_load_op;
        end
    end

    // SRAM data is only valid in the first WB cycle; keep it for the rest
    // of the residency so a stalled load still writes the right value.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_buf <= 32'd0;
        end else if (ws_first) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    assign rd        = ws_first ? data_sram_rdata : rdata_buf;
    assign ws_result = load_align(ws_load_op, ws_alu_result[1:0], ws_alu_result,
                                  ws_rt_value, rd);

    assign rf_we    = ws_valid && ws_gr_we && ws_ready_go && (ws_dest != 5'd0);
    assign rf_waddr = ws_dest;
    assign rf_wdata = ws_result;

    assign ws_fwd_dest = (ws_valid && ws_gr_we) ? ws_dest : 5'd0;
    assign ws_fwd_data = ws_result;

    assign debug_wb_pc       = ws_pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_dest;
    assign debug_wb_rf_wdata = ws_result;

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the 5-stage MIPS pipeline, directly downstream of `memory_stage`. It holds the MEM/WB pipeline register and takes in the synchronous data SRAM read data, which returns one cycle after `memory_stage` drives the address. It aligns and extends load data (including LWL/LWR merge), drives the register-file write port, supplies bypass data to decode, and drives the debug trace interface. It supports a hold input, with an internal read-data buffer so SRAM data is not lost while stalled.

## Interface
Parameters: none.
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- ms_valid  in  1  memory stage presents a valid instruction this cycle
- ms_pc  in  32  instruction PC
- ms_alu_result  in  32  ALU result / load address; bits [1:0] give the byte offset
- ms_rt_value  in  32  rt register value, used for the LWL/LWR merge
- ms_dest  in  5  destination register number
- ms_gr_we  in  1  instruction writes the GPR file
- ms_load_op  in  3  0 none (write alu_result), 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR
- data_sram_rdata  in  32  SRAM read data, valid only in the first cycle an instruction occupies WB
- ws_hold  in  1  external stall; WB keeps its current instruction
- ws_allowin  out  1  WB accepts a new instruction at the next edge
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- ws_fwd_dest  out  5  bypass destination; 0 means no bypass
- ws_fwd_data  out  32  bypass data; equals rf_wdata
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_wen  out  4  trace byte write enables: {4{rf_we}}
- debug_wb_rf_wnum  out  5  trace register number
- debug_wb_rf_wdata  out  32  trace write data

## Operation
- Handshake:
  - ws_ready_go = !ws_hold.
  - ws_allowin = !ws_valid || ws_ready_go.
  - The stage only accepts a new instruction when the current one can leave (no skid entry).
- ws_valid update: when ws_allowin, ws_valid <= ms_valid; otherwise it holds.
- Payload capture: pc, alu_result, rt_value, dest, gr_we and load_op are captured only when ms_valid && ws_allowin. Otherwise the payload holds its value.
- First-cycle flag: ws_first is set when a new instruction is captured and cleared after one cycle.
- Read-data buffer: while ws_first, rdata_buf <= data_sram_rdata.
- Selected read data: rd = ws_first ? data_sram_rdata : rdata_buf.
- Load data, with k = alu_result[1:0]:
  - LB/LBU: rd byte k, sign- or zero-extended.
  - LH/LHU: halfword selected by k[1], sign- or zero-extended; k[0] is ignored because alignment faults are handled upstream.
  - LW: rd.
  - LWL: (rd << 8*(3-k)) | (rt_value & low 8*(3-k) bits mask).
  - LWR: (rd >> 8*k) | (rt_value & high 8*k bits mask).
  - load_op 0: alu_result.
- Register-file write:
  - rf_we = ws_valid && ws_gr_we && ws_ready_go && (ws_dest != 0).
  - rf_waddr = ws_dest; rf_wdata = the result above.
- Bypass: ws_fwd_dest = (ws_valid && ws_gr_we) ? ws_dest : 0. It stays driven throughout a hold; ws_fwd_data is stable during the hold because it uses rdata_buf.
- Debug trace: debug_* mirror rf_we, rf_waddr and rf_wdata; debug_wb_pc = ws_pc.

## Timing
- Reset (resetn low at the edge) clears ws_valid, ws_first, rdata_buf and the whole payload to 0. As a result:
  - all outputs are 0, except ws_allowin = 1;
  - reset during a hold discards the held instruction with no write.
- Latency: an instruction accepted at edge N writes the register file in cycle N..N+1 if ws_hold is low, i.e. one cycle of residency.
- Hold of H cycles: residency is 1+H cycles.
  - Exactly one rf_we pulse, in the first cycle with ws_hold low.
  - ws_allowin = 0 throughout the hold.
- A new instruction and a departing one in the same cycle give back-to-back writes with no bubble.
- SRAM data arriving after the first cycle is ignored; the buffer is never overwritten mid-residency.
- An ms_valid pulse while ws_allowin = 0 is not captured; `memory_stage` must hold it.

## Test plan
- Reset: hold resetn low 2 cycles with random inputs -> all outputs 0, ws_allowin = 1.
- LW: alu_result 0x00001000, dest 5, rdata 0x8899AABB in the WB cycle -> rf_we = 1, rf_waddr = 5, rf_wdata = 0x8899AABB, debug_wb_rf_wen = 0xF.
- Extension cases, rdata 0x80112233:
  - LB, k=3 -> 0xFFFFFF80
  - LBU, k=3 -> 0x00000080
  - LH, k=2 -> 0xFFFF8011
  - LHU, k=0 -> 0x00002233
- Merge cases, rt_value 0x11223344, rdata 0xAABBCCDD:
  - LWL, k=1 -> 0xCCDD3344
  - LWR, k=1 -> 0x11AABBCC
- Hold: LW with rdata 0xDEADBEEF, ws_hold high 3 cycles while rdata changes to 0x0 -> ws_allowin = 0 and rf_we = 0 for 3 cycles, then a single rf_we pulse with wdata 0xDEADBEEF. ws_fwd_data = 0xDEADBEEF throughout.
- Back-to-back ALU ops:
  - dest 3 value 7, then dest 0 value 9 -> rf_we on the first, none on the second; ws_fwd_dest = 3, then 0.
  - Reset asserted mid-hold -> no write occurs, outputs return to 0.
